// File: rtl/hdlc_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : hdlc_bus_scheduler
// Purpose : Half-duplex RS-485 line scheduler. Grants the transmitter to one
//           of NREQ requesters (round-robin) once the line has been idle for
//           IDLE_GAP bit-clocks, frames the transmission with driver-enable
//           guard times, watchdogs the transmitter and hands the line back to
//           the receiver.
// Ports   : clk          bit clock, one RS-485 bit per cycle
//           rst          asynchronous reset, active-low
//           req          per-requester transmit request (level)
//           rx           raw line level (idle = 1)
//           rx_busy      receiver frame-in-progress flag
//           tx_done      transmitter last-bit pulse
//           gnt          one-hot grant, held from PRE through POST
//           tx_sel       index of the granted requester
//           tx_start     one-cycle start pulse to the transmitter
//           de / re_n    RS-485 driver enable / receiver enable (re_n = de)
//           collision    pulse: receiver went busy during PRE, grant aborted
//           timeout_err  pulse: transmitter never reported tx_done
// Revision: 1.0 - initial release
// ============================================================================
module hdlc_bus_scheduler #(
  parameter int NREQ       = 4,
  parameter int SEL_W      = 2,
  parameter int IDLE_GAP   = 8,
  parameter int GUARD_PRE  = 2,
  parameter int GUARD_POST = 2,
  parameter int TX_TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             rx,
  input  logic             rx_busy,
  input  logic             tx_done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] tx_sel,
  output logic             tx_start,
  output logic             de,
  output logic             re_n,
  output logic             collision,
  output logic             timeout_err
);

  localparam int c_idle_w = $clog2(IDLE_GAP + 1);
  localparam int c_pre_w  = $clog2(GUARD_PRE + 1);
  localparam int c_post_w = $clog2(GUARD_POST + 1);
  localparam int c_tmr_w  = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_SEND = 2'd2,
    S_POST = 2'd3
  } state_t;

  state_t              r_state,       w_state;
  logic [c_idle_w-1:0] r_idle_cnt,    w_idle_cnt;
  logic [c_pre_w-1:0]  r_pre_cnt,     w_pre_cnt;
  logic [c_post_w-1:0] r_post_cnt,    w_post_cnt;
  logic [c_tmr_w-1:0]  r_timer,       w_timer;
  logic [NREQ-1:0]     r_gnt,         w_gnt;
  logic [SEL_W-1:0]    r_tx_sel,      w_tx_sel;
  logic [SEL_W-1:0]    r_last,        w_last;
  logic                r_tx_start,    w_tx_start;
  logic                r_de,          w_de;
  logic                r_re_n,        w_re_n;
  logic                r_collision,   w_collision;
  logic                r_timeout_err, w_timeout_err;

  // Round-robin pick: first asserted request strictly after the last winner.
  logic [SEL_W-1:0] w_winner;
  logic [NREQ-1:0]  w_onehot;
  logic             w_found;

  always_comb begin
    int idx;
    idx      = 0;
    w_winner = '0;
    w_onehot = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(r_last) + i) % NREQ;
      if (!w_found && req[idx]) begin
        w_found       = 1'b1;
        w_winner      = SEL_W'(idx);
        w_onehot[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state       = r_state;
    w_idle_cnt    = r_idle_cnt;
    w_pre_cnt     = r_pre_cnt;
    w_post_cnt    = r_post_cnt;
    w_timer       = r_timer;
    w_gnt         = r_gnt;
    w_tx_sel      = r_tx_sel;
    w_last        = r_last;
    w_de          = r_de;
    w_re_n        = r_re_n;
    w_tx_start    = 1'b0;
    w_collision   = 1'b0;
    w_timeout_err = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx && !rx_busy) begin
          if (r_idle_cnt != c_idle_w'(IDLE_GAP))
            w_idle_cnt = r_idle_cnt + c_idle_w'(1);
        end else begin
          w_idle_cnt = '0;
        end
        if (w_found && (r_idle_cnt == c_idle_w'(IDLE_GAP))) begin
          w_state    = S_PRE;
          w_gnt      = w_onehot;
          w_tx_sel   = w_winner;
          w_de       = 1'b1;
          w_re_n     = 1'b1;
          w_pre_cnt  = '0;
          w_idle_cnt = '0;
        end
      end

      S_PRE: begin
        // Another station started talking while we were turning the driver
        // on: back off. r_last is untouched so this requester retries first.
        if (rx_busy) begin
          w_collision = 1'b1;
          w_gnt       = '0;
          w_de        = 1'b0;
          w_re_n      = 1'b0;
          w_state     = S_IDLE;
        end else if (r_pre_cnt == c_pre_w'(GUARD_PRE - 1)) begin
          w_tx_start = 1'b1;
          w_timer    = '0;
          w_state    = S_SEND;
        end else begin
          w_pre_cnt = r_pre_cnt + c_pre_w'(1);
        end
      end

      S_SEND: begin
        // rx_busy is our own echo here and is deliberately ignored.
        if (tx_done) begin
          w_post_cnt = '0;
          w_state    = S_POST;
        end else if (r_timer == c_tmr_w'(TX_TIMEOUT - 1)) begin
          w_timeout_err = 1'b1;
          w_post_cnt    = '0;
          w_state       = S_POST;
        end else begin
          w_timer = r_timer + c_tmr_w'(1);
        end
      end

      S_POST: begin
        if (r_post_cnt == c_post_w'(GUARD_POST - 1)) begin
          w_de       = 1'b0;
          w_re_n     = 1'b0;
          w_gnt      = '0;
          w_last     = r_tx_sel;
          w_idle_cnt = '0;
          w_state    = S_IDLE;
        end else begin
          w_post_cnt = r_post_cnt + c_post_w'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_idle_cnt    <= '0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_timer       <= '0;
      r_gnt         <= '0;
      r_tx_sel      <= '0;
      r_last        <= SEL_W'(NREQ - 1);
      r_tx_start    <= 1'b0;
      r_de          <= 1'b0;
      r_re_n        <= 1'b0;
      r_collision   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_idle_cnt    <= w_idle_cnt;
      r_pre_cnt     <= w_pre_cnt;
      r_post_cnt    <= w_post_cnt;
      r_timer       <= w_timer;
      r_gnt         <= w_gnt;
      r_tx_sel      <= w_tx_sel;
      r_last        <= w_last;
      r_tx_start    <= w_tx_start;
      r_de          <= w_de;
      r_re_n        <= w_re_n;
      r_collision   <= w_collision;
      r_timeout_err <= w_timeout_err;
    end
  end

  assign gnt         = r_gnt;
  assign tx_sel      = r_tx_sel;
  assign tx_start    = r_tx_start;
  assign de          = r_de;
  assign re_n        = r_re_n;
  assign collision   = r_collision;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_hdlc_bus_scheduler
// Purpose : Self-checking bench for hdlc_bus_scheduler. The driver predicts
//           each output event (grant, start, timeout, collision, de release)
//           from the line rules and queues it; a negedge monitor pops and
//           compares whenever the DUT shows such an event.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hdlc_bus_scheduler;

  localparam int NREQ       = 4;
  localparam int SEL_W      = 2;
  localparam int IDLE_GAP   = 8;
  localparam int GUARD_PRE  = 2;
  localparam int GUARD_POST = 2;
  localparam int TX_TIMEOUT = 128;

  localparam int EV_GNT    = 0;
  localparam int EV_START  = 1;
  localparam int EV_TMO    = 2;
  localparam int EV_COLL   = 3;
  localparam int EV_DEFALL = 4;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } exp_t;

  exp_t exp_q[$];

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic             rx;
  logic             rx_busy;
  logic             tx_done;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] tx_sel;
  logic             tx_start;
  logic             de;
  logic             re_n;
  logic             collision;
  logic             timeout_err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state: length of the current qualified idle run and the
  // requester that most recently completed a frame.
  int m_idle;
  int m_last;

  hdlc_bus_scheduler #(
    .NREQ(NREQ), .SEL_W(SEL_W), .IDLE_GAP(IDLE_GAP), .GUARD_PRE(GUARD_PRE),
    .GUARD_POST(GUARD_POST), .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rx(rx), .rx_busy(rx_busy),
    .tx_done(tx_done), .gnt(gnt), .tx_sel(tx_sel), .tx_start(tx_start),
    .de(de), .re_n(re_n), .collision(collision), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic string ev_name(input int k);
    case (k)
      EV_GNT:   return "gnt";
      EV_START: return "tx_start";
      EV_TMO:   return "timeout_err";
      EV_COLL:  return "collision";
      default:  return "de_fall";
    endcase
  endfunction

  task automatic push(input int kind, input int c, input int v);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input int kind, input int val);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event %s: seen at cycle %0d val %0d, none expected",
               ev_name(kind), cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        errors++;
        $display("FAIL event %s: got %s@%0d val %0d, expected %s@%0d val %0d",
                 ev_name(kind), ev_name(kind), cyc, val, ev_name(e.kind), e.cyc, e.val);
      end
    end
  endtask

  // Monitor
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_de  = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (prev_gnt == '0 && gnt != '0) expect_event(EV_GNT, int'({tx_sel, gnt}));
      if (tx_start)                    expect_event(EV_START, 0);
      if (timeout_err)                 expect_event(EV_TMO, 0);
      if (collision)                   expect_event(EV_COLL, 0);
      if (prev_de && !de)              expect_event(EV_DEFALL, 0);
      checks++;
      if (re_n !== de || de !== (gnt != '0)) begin
        errors++;
        $display("FAIL enables at cycle %0d: de=%b re_n=%b gnt=%b, need re_n=de=(gnt!=0)",
                 cyc, de, re_n, gnt);
      end
      if (prev_gnt != '0 && gnt != '0) begin
        checks++;
        if (gnt !== prev_gnt) begin
          errors++;
          $display("FAIL gnt_hold at cycle %0d: gnt=%b, held value %b", cyc, gnt, prev_gnt);
        end
      end
      prev_gnt = gnt;
      prev_de  = de;
    end else begin
      prev_gnt = '0;
      prev_de  = 1'b0;
    end
  end

  // One bit-clock of stimulus; the edge that samples it is cyc+1.
  task automatic step(input logic [NREQ-1:0] r, input logic x, input logic b, input logic d);
    req     = r;
    rx      = x;
    rx_busy = b;
    tx_done = d;
    @(negedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic check_zero(input string name);
    checks++;
    if ({gnt, tx_sel, tx_start, de, re_n, collision, timeout_err} !== '0) begin
      errors++;
      $display("FAIL %s: gnt=%b tx_sel=%0d tx_start=%b de=%b re_n=%b coll=%b tmo=%b, all must be 0",
               name, gnt, tx_sel, tx_start, de, re_n, collision, timeout_err);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected event(s) never seen, next %s@%0d",
               name, exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // mode: 0 random, 1 tx_done after 'delay' cycles, 2 collision in PRE cycle
  // 'delay', 3 transmitter silent (timeout). abort>=0 stops driving that many
  // cycles into SEND.
  task automatic episode(input logic [NREQ-1:0] reqpat, input int noise, input bit pat,
                         input int mode, input int delay, input int abort);
    logic [63:0]     rx_pat;
    logic [NREQ-1:0] r;
    logic            x, b;
    int              e, w, s, d, j, md, dl;
    bit              granted;
    rx_pat  = 64'h7E0100101100107E;
    granted = 1'b0;
    e = 0; w = 0; s = 0; d = 0; j = 0;
    md = mode; dl = delay;
    for (int i = 0; i < 400 && !granted; i++) begin
      if (i < noise) begin
        if (pat) begin
          r = reqpat; x = rx_pat[63 - (i % 64)]; b = 1'b1;
        end else begin
          r = NREQ'($urandom); x = ($urandom_range(0, 3) != 0); b = ($urandom_range(0, 4) == 0);
        end
      end else begin
        r = reqpat; x = 1'b1; b = 1'b0;
      end
      e = cyc + 1;
      if (m_idle >= IDLE_GAP && r != '0) begin
        granted = 1'b1;
        w = rr_pick(m_last, r);
        push(EV_GNT, e, (w << NREQ) | (1 << w));
        if (md == 0) begin
          case ($urandom_range(1, 6))
            5:       begin md = 2; dl = $urandom_range(0, GUARD_PRE - 1); end
            6:       md = 3;
            default: begin
              md = 1;
              dl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, TX_TIMEOUT)
                                               : $urandom_range(1, 24);
            end
          endcase
        end
        if (md == 2) begin
          j = dl;
          push(EV_COLL, e + 1 + j, 0);
          push(EV_DEFALL, e + 1 + j, 0);
        end else begin
          s = e + GUARD_PRE;
          push(EV_START, s, 0);
          if (md == 3) begin
            d = s + TX_TIMEOUT;
            push(EV_TMO, d, 0);
          end else begin
            d = s + dl;
          end
          push(EV_DEFALL, d + GUARD_POST, 0);
        end
      end
      if (granted)           m_idle = 0;
      else if (x && !b)      m_idle = (m_idle < IDLE_GAP) ? m_idle + 1 : IDLE_GAP;
      else                   m_idle = 0;
      step(r, x, b, ($urandom_range(0, 7) == 0));
    end
    if (md == 2) begin
      for (int jj = 0; jj <= j; jj++)
        step(NREQ'($urandom), 1'($urandom), (jj == j), 1'($urandom));
      m_idle = 0;
    end else begin
      for (int jj = 0; jj < GUARD_PRE; jj++)
        step(NREQ'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      for (int t = s + 1; t <= d; t++) begin
        if (abort >= 0 && t > s + abort) return;
        step(NREQ'($urandom), 1'($urandom), 1'($urandom), (md != 3) && (t == d));
      end
      for (int t = 0; t < GUARD_POST; t++)
        step(NREQ'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      m_last = w;
      m_idle = 0;
    end
    check_drained("episode_events");
  endtask

  initial begin
    rst = 1'b0; req = '0; rx = 1'b1; rx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_state");
    m_idle = 0;
    m_last = NREQ - 1;
    rst    = 1'b1;
    mon_en = 1'b1;

    episode(4'b0001, 0, 1'b0, 1, 64, -1);           // first grant after idle gap
    episode(4'b0101, 0, 1'b0, 1, 64, -1);           // round-robin alternation
    episode(4'b0101, 0, 1'b0, 1, 64, -1);
    episode(4'b0101, 0, 1'b0, 1, 64, -1);
    episode(4'b0010, 64, 1'b1, 1, 30, -1);          // busy receiver holds off
    episode(4'b1000, 0, 1'b0, 2, 0, -1);            // collision right after gnt
    episode(4'b1001, 0, 1'b0, 1, 20, -1);           // aborted requester retries first
    episode(4'b0100, 0, 1'b0, 3, 0, -1);            // transmitter timeout
    episode(4'b0001, 0, 1'b0, 1, TX_TIMEOUT, -1);   // tx_done on the timeout cycle
    episode(4'b0010, 0, 1'b0, 2, GUARD_PRE - 1, -1);// collision on last PRE cycle

    for (int n = 0; n < 30; n++) begin
      logic [NREQ-1:0] rp;
      rp = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      episode(rp, $urandom_range(0, 15), 1'b0, 0, 0, -1);
    end

    // Asynchronous reset in the middle of a frame.
    episode(4'b0010, 0, 1'b0, 1, 60, 10);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    check_zero("reset_hold");
    m_idle = 0;
    m_last = NREQ - 1;
    rst    = 1'b1;
    mon_en = 1'b1;
    episode(4'b1111, 0, 1'b0, 1, 20, -1);           // req[0] first after reset

    check_drained("final_queue");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
